board_io_ctrl: RTL and testbench

- Parametrised board-support block between FPGA pins (push-buttons, LEDs, UART/activity lines) and the tinyQV core.
- Replaces ad-hoc top-level glue with:
  - synchronised, debounced buttons;
  - a stretched core reset generated from selected buttons;
  - a heartbeat LED;
  - pulse-stretched activity LEDs;
  - software-driven LEDs.
- All timing is set by cycle-count parameters, so one block serves any board clock.

---
 rtl/board_io_ctrl.sv | 168 ++++++++++++++++
 tb/tb_board_io_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// Board-support glue between FPGA pins and the tinyQV core: synchronised and
// debounced buttons, a stretched core reset driven by selected buttons, a
// heartbeat LED, pulse-stretched activity LEDs and software-driven LEDs.
// All timing comes from cycle-count parameters so any board clock can be used.
module board_io_ctrl #(
    parameter int                 NUM_BTN         = 2,
    parameter int                 NUM_ACT         = 2,
    parameter int                 NUM_LED         = 6,
    parameter int                 DB_CYCLES       = 270000,
    parameter logic [NUM_BTN-1:0] RST_MASK        = {NUM_BTN{1'b1}},
    parameter int                 RST_HOLD_CYCLES = 2700,
    parameter int                 HB_HALF_CYCLES  = 13500000,
    parameter int                 STRETCH_CYCLES  = 540000,
    parameter logic [NUM_ACT-1:0] ACT_IDLE        = {NUM_ACT{1'b1}},
    parameter bit                 LED_ACTIVE_LOW  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_BTN-1:0]         btn_raw,
    input  logic [NUM_ACT-1:0]         act_in,
    input  logic [NUM_LED-NUM_ACT-2:0] led_sw,
    output logic [NUM_BTN-1:0]         btn_level,
    output logic [NUM_BTN-1:0]         btn_press,
    output logic                       core_rst_n,
    output logic [NUM_LED-1:0]         led
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int RH_W = (RST_HOLD_CYCLES > 0) ? $clog2(RST_HOLD_CYCLES + 1) : 1;
    localparam int HB_W = (HB_HALF_CYCLES > 1) ? $clog2(HB_HALF_CYCLES) : 1;
    localparam int ST_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [NUM_LED-1:0] LED_POL = {NUM_LED{LED_ACTIVE_LOW}};

    logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q;
    logic [NUM_ACT-1:0] act_s1_q, act_s2_q, act_prev_q;
    logic [NUM_ACT-1:0] act_lit_d;

    // Two-flop synchronisers; activity lines also keep their previous sample for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            act_s1_q   <= ACT_IDLE;
            act_s2_q   <= ACT_IDLE;
            act_prev_q <= ACT_IDLE;
        end else begin
            btn_s1_q   <= btn_raw;
            btn_s2_q   <= btn_s1_q;
            act_s1_q   <= act_in;
            act_s2_q   <= act_s1_q;
            act_prev_q <= act_s2_q;
        end
    end

    // Per-button debounce: level only moves after DB_CYCLES consecutive differing samples
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            lvl_q, lvl_d, lvl_dly_q, press_q;

        // Next-state for the stability counter and accepted level
        always_comb begin
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            if (btn_s2_q[gi] == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
                lvl_d = btn_s2_q[gi];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Debounce state; press fires the cycle after the accepted level rises
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q     <= '0;
                lvl_q     <= 1'b0;
                lvl_dly_q <= 1'b0;
                press_q   <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                lvl_q     <= lvl_d;
                lvl_dly_q <= lvl_q;
                press_q   <= lvl_q & ~lvl_dly_q;
            end
        end

        assign btn_level[gi] = lvl_q;
        assign btn_press[gi] = press_q;
    end

    // Per-channel activity stretch: any edge reloads the on-time to full length
    for (genvar gi = 0; gi < NUM_ACT; gi++) begin : g_act
        logic [ST_W-1:0] cnt_q, cnt_d;

        // Reload on edge, otherwise count down to zero
        always_comb begin
            cnt_d = cnt_q;
            if (act_s2_q[gi] ^ act_prev_q[gi]) begin
                cnt_d = ST_W'(STRETCH_CYCLES);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        // Stretch counter register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign act_lit_d[gi] = (cnt_d != '0);
    end

    logic            rst_cause;
    logic [RH_W-1:0] hold_q, hold_d;
    logic            core_rst_n_q, core_rst_n_d;
    logic [HB_W-1:0] pre_q, pre_d;
    logic            hb_q, hb_d;
    logic [NUM_LED-1:0] led_q, led_logic_d;

    assign rst_cause = |(btn_level & RST_MASK);

    // Core-reset hold counter, heartbeat prescaler and LED next values
    always_comb begin
        hold_d = hold_q;
        if (rst_cause) begin
            hold_d = RH_W'(RST_HOLD_CYCLES);
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
        core_rst_n_d = ~rst_cause & (hold_d == '0);

        pre_d = pre_q + 1'b1;
        hb_d  = hb_q;
        if (pre_q == HB_W'(HB_HALF_CYCLES - 1)) begin
            pre_d = '0;
            hb_d  = ~hb_q;
        end

        led_logic_d = {led_sw, act_lit_d, hb_d};
    end

    // Reset generator, heartbeat and the registered LED pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= RH_W'(RST_HOLD_CYCLES);
            core_rst_n_q <= 1'b0;
            pre_q        <= '0;
            hb_q         <= 1'b0;
            led_q        <= LED_POL;
        end else begin
            hold_q       <= hold_d;
            core_rst_n_q <= core_rst_n_d;
            pre_q        <= pre_d;
            hb_q         <= hb_d;
            led_q        <= led_logic_d ^ LED_POL;
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign led        = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl: expectations are queued with a target
// cycle when stimulus is driven and compared on the falling edge of that cycle.
module tb_board_io_ctrl;

    localparam int SEL_LED   = 0;
    localparam int SEL_LED0  = 1;
    localparam int SEL_LED1  = 2;
    localparam int SEL_LED2  = 3;
    localparam int SEL_LEDSW = 4;
    localparam int SEL_RST   = 5;
    localparam int SEL_BLV   = 6;
    localparam int SEL_BPR   = 7;

    typedef struct {
        int         cyc;
        int         sel;
        logic [5:0] exp;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_raw = 2'b00;
    logic [1:0] act_in = 2'b11;
    logic [2:0] led_sw = 3'b000;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic       core_rst_n;
    logic [5:0] led;

    int        cyc = 0;
    int        n_total = 0;
    int        n_bad = 0;
    sb_entry_t sb[$];

    board_io_ctrl #(
        .NUM_BTN(2), .NUM_ACT(2), .NUM_LED(6), .DB_CYCLES(4),
        .RST_MASK(2'b11), .RST_HOLD_CYCLES(3), .HB_HALF_CYCLES(8),
        .STRETCH_CYCLES(5), .ACT_IDLE(2'b11), .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .act_in(act_in),
        .led_sw(led_sw), .btn_level(btn_level), .btn_press(btn_press),
        .core_rst_n(core_rst_n), .led(led)
    );

    always #5 clk = ~clk;

    // Cycle number = count of rising edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push(input int c, input int sel, input logic [5:0] v);
        sb_entry_t e;
        e.cyc = c;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    function automatic logic [5:0] obs(input int sel);
        case (sel)
            SEL_LED:   obs = led;
            SEL_LED0:  obs = {5'b0, led[0]};
            SEL_LED1:  obs = {5'b0, led[1]};
            SEL_LED2:  obs = {5'b0, led[2]};
            SEL_LEDSW: obs = {3'b0, led[5:3]};
            SEL_RST:   obs = {5'b0, core_rst_n};
            SEL_BLV:   obs = {4'b0, btn_level};
            default:   obs = {4'b0, btn_press};
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            SEL_LED:   sel_name = "led";
            SEL_LED0:  sel_name = "led0_hb";
            SEL_LED1:  sel_name = "led1_act0";
            SEL_LED2:  sel_name = "led2_act1";
            SEL_LEDSW: sel_name = "led_sw_bits";
            SEL_RST:   sel_name = "core_rst_n";
            SEL_BLV:   sel_name = "btn_level";
            default:   sel_name = "btn_press";
        endcase
    endfunction

    // Heartbeat LED pin (active low) expected at cycle c after release
    function automatic logic [5:0] hb_pin(input int c);
        hb_pin = (((c / 8) % 2) == 1) ? 6'd0 : 6'd1;
    endfunction

    // Compare every queued expectation that targets the current cycle
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    check_eq($sformatf("%s@%0d", sel_name(sb[i].sel), cyc), 32'(obs(sb[i].sel)), 32'(sb[i].exp));
                    sb.delete(i);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) check_eq("wait_cyc", 32'(cyc), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Values while held in reset
        #12;
        check_eq("rst_led", 32'(led), 32'h3f);
        check_eq("rst_core_rst_n", 32'(core_rst_n), 32'h0);
        check_eq("rst_btn_level", 32'(btn_level), 32'h0);
        check_eq("rst_btn_press", 32'(btn_press), 32'h0);
        #10;
        rst_n = 1'b1;

        // Reset release: heartbeat, core reset stretch, idle LEDs
        for (int c = 1; c <= 144; c++) push(c, SEL_LED0, hb_pin(c));
        for (int c = 1; c <= 7; c++)   push(c, SEL_LED, 6'h3f);
        push(1, SEL_RST, 6'd0);
        push(2, SEL_RST, 6'd0);
        for (int c = 3; c <= 26; c++)  push(c, SEL_RST, 6'd1);
        for (int c = 1; c <= 25; c++) begin
            push(c, SEL_BLV, 6'd0);
            push(c, SEL_BPR, 6'd0);
        end

        // Button 0 held: debounce latency, single press pulse, core reset
        wait_cyc(20);
        btn_raw[0] = 1'b1;
        for (int c = 26; c <= 40; c++) push(c, SEL_BLV, 6'd1);
        push(26, SEL_BPR, 6'd0);
        push(27, SEL_BPR, 6'd1);
        push(28, SEL_BPR, 6'd0);
        for (int c = 27; c <= 43; c++) push(c, SEL_RST, 6'd0);

        // Release: level falls at 41, core reset rises 3 cycles later, no press on fall
        wait_cyc(35);
        btn_raw[0] = 1'b0;
        push(41, SEL_BLV, 6'd0);
        push(41, SEL_BPR, 6'd0);
        push(42, SEL_BPR, 6'd0);
        for (int c = 44; c <= 75; c++) push(c, SEL_RST, 6'd1);

        // Button 1 glitches shorter than the debounce window
        wait_cyc(50);
        btn_raw[1] = 1'b1;
        for (int c = 50; c <= 75; c++) begin
            push(c, SEL_BLV, 6'd0);
            push(c, SEL_BPR, 6'd0);
        end
        wait_cyc(53);
        btn_raw[1] = 1'b0;
        wait_cyc(54);
        btn_raw[1] = 1'b1;
        wait_cyc(57);
        btn_raw[1] = 1'b0;

        // Single activity edge on channel 0
        wait_cyc(80);
        act_in[0] = 1'b0;
        for (int c = 80; c <= 120; c++) push(c, SEL_LED2, 6'd1);
        push(82, SEL_LED1, 6'd1);
        for (int c = 83; c <= 87; c++) push(c, SEL_LED1, 6'd0);
        push(88, SEL_LED1, 6'd1);

        // Retrigger on the third lit cycle extends the on-time
        wait_cyc(100);
        act_in[0] = 1'b1;
        push(102, SEL_LED1, 6'd1);
        for (int c = 103; c <= 112; c++) push(c, SEL_LED1, 6'd0);
        push(113, SEL_LED1, 6'd1);
        wait_cyc(105);
        act_in[0] = 1'b0;

        // Software LEDs
        wait_cyc(120);
        led_sw = 3'b101;
        push(120, SEL_LEDSW, 6'b000111);
        push(121, SEL_LEDSW, 6'b000010);
        wait_cyc(125);
        led_sw = 3'b000;
        push(125, SEL_LEDSW, 6'b000010);
        push(126, SEL_LEDSW, 6'b000111);

        // Start a stretch and a debounce, then reset in the middle of both
        wait_cyc(140);
        act_in[0] = 1'b1;
        btn_raw[0] = 1'b1;
        led_sw = 3'b111;
        for (int c = 141; c <= 144; c++) push(c, SEL_LEDSW, 6'd0);
        push(143, SEL_LED1, 6'd0);
        push(144, SEL_LED1, 6'd0);
        push(143, SEL_BLV, 6'd0);
        push(144, SEL_BLV, 6'd0);
        wait_cyc(144);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_led", 32'(led), 32'h3f);
        check_eq("midrst_core_rst_n", 32'(core_rst_n), 32'h0);
        check_eq("midrst_btn_level", 32'(btn_level), 32'h0);
        check_eq("midrst_btn_press", 32'(btn_press), 32'h0);
        sb.delete();
        btn_raw = 2'b00;
        act_in = 2'b11;
        led_sw = 3'b000;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // After the second release everything restarts from reset values
        for (int c = 1; c <= 16; c++) begin
            push(c, SEL_BLV, 6'd0);
            push(c, SEL_BPR, 6'd0);
            push(c, SEL_LED1, 6'd1);
            push(c, SEL_LED0, hb_pin(c));
            push(c, SEL_RST, (c >= 3) ? 6'd1 : 6'd0);
        end
        for (int c = 1; c <= 7; c++) push(c, SEL_LED, 6'h3f);

        wait_cyc(20);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
